snake_game_ctrl: RTL
====================

// Module: snake_game_ctrl
// PURPOSE
// Top-level game-flow controller for the Snake VGA design. Sequences title/background
// screen vs. game rendering (drives vga_wrapper game_enable), generates snake movement
// ticks locked to the VGA frame rate, and keeps the score. Sits between button inputs,
// the VGA sync generator (frame timing) and the snake/apple logic (collision, eat).
// PARAMETERS
// BASE_PERIOD      default 8   frames per move tick at start of a game (>=2)
// MIN_PERIOD       default 2   fastest allowed frames per move tick (>=1, <=BASE_PERIOD)
// APPLES_PER_LEVEL default 4   apples eaten per speed-level increment (SPEEDUP_EN only)
// PORTS
// clock_25     in   1  pixel clock, all logic on rising edge
// reset        in   1  synchronous, active-high; clears all state
// start_btn    in   1  start/restart button, active-high level, debounced upstream
// pause_btn    in   1  pause toggle button, active-high level, debounced upstream
// vga_vs       in   1  VGA vertical sync (active low) from sync generator
// collision    in   1  1-cycle pulse: snake hit wall/itself
// apple_eaten  in   1  1-cycle pulse: snake head on apple
// game_enable  out  1  1 = render game layer; 0 = background/title only
// game_state   out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
// move_tick    out  1  1-cycle pulse: advance snake one cell
// init_snake   out  1  1-cycle pulse: reinitialise snake/apple positions
// grow         out  1  1-cycle pulse: lengthen snake (registered copy of accepted eat)
// score        out  8  apples eaten this game, saturates at 255
// speed_level  out  4  current speed level
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; frame counter 0; edge-detect regs 0.
// - Buttons edge-detected: press = input 1 and registered previous 0. Held button = one press.
// - frame_tick = vga_vs falling edge (registered vga_vs 1, current 0); one per frame.
// - FSM (transition takes effect the cycle after the event; outputs registered):
//   IDLE : start press -> PLAY, init_snake=1 that cycle, score:=0, level:=0, frame cnt:=0.
//   PLAY : collision -> OVER; else pause press -> PAUSE.
//   PAUSE: pause press -> PLAY; start press ignored; collision/apple ignored.
//   OVER : start press -> PLAY (same actions as from IDLE). Score held for display.
// - game_enable = 1 in PLAY, PAUSE, OVER; 0 in IDLE.
// - Frame counter: counts frame_ticks only in PLAY; frozen in PAUSE/OVER/IDLE.
//   When frame_tick and count == period-1: move_tick=1 next cycle, count:=0.
//   First move_tick of a game occurs on the period-th frame_tick after entering PLAY.
// - apple_eaten in PLAY: score+1 (saturate 255), grow=1 next cycle. Ignored elsewhere.
// - Simultaneous: collision+apple_eaten same cycle -> OVER, no score/grow.
//   collision+pause press -> OVER. start+pause press in IDLE/OVER -> PLAY (pause ignored).
//   Resuming PAUSE->PLAY keeps frame count (no extra/lost tick).
// - reset asserted mid-game: next cycle state IDLE, pulses cleared, score 0.
// CONFIGURATION
// SPEEDUP_EN defined: apples counter wraps every APPLES_PER_LEVEL accepted apples and
//   increments speed_level (saturate 15); period = max(BASE_PERIOD - speed_level,
//   MIN_PERIOD), new period used from next counter wrap. Level reset on new game.
// SPEEDUP_EN undefined: period fixed = BASE_PERIOD; speed_level tied 0; no level logic.
// TESTING
// 1 reset high 3 cycles -> state 00, game_enable 0, score 0, no pulses; vga_vs toggling
//   in IDLE -> no move_tick.
// 2 start held 10 cycles in IDLE -> exactly one init_snake pulse, state 01; with
//   BASE_PERIOD=8, move_tick on 8th vga_vs fall, then every 8 frames.
// 3 PLAY, pause press after 3 frames, 20 frames paused, pause again -> no ticks while
//   paused; next move_tick 5 frames after resume.
// 4 collision and apple_eaten same cycle with score 5 -> state 11, score stays 5, grow 0;
//   start press -> PLAY, score 0, init_snake pulse.
// 5 260 apple_eaten pulses in PLAY -> score 255, 260 grow pulses.
// 6 SPEEDUP_EN, APPLES_PER_LEVEL=4: 8 apples -> speed_level 2, tick interval 6 frames;
//   without macro: speed_level 0, interval stays 8.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
//
// Game-flow controller for the Snake VGA design. It decides whether the game
// layer is rendered (title/background versus game), produces snake movement
// ticks that are locked to the VGA frame rate, and keeps the score.
//
// Optional feature macro: SPEEDUP_EN
//   defined   : every APPLES_PER_LEVEL accepted apples raise speed_level
//               (saturating at 15). The move period becomes
//               max(BASE_PERIOD - speed_level, MIN_PERIOD). A new period only
//               takes effect at the next frame-counter wrap.
//   undefined : the move period is fixed at BASE_PERIOD and speed_level is 0.
//
// Parameters
//   BASE_PERIOD       frames per move tick at the start of a game (>= 2)
//   MIN_PERIOD        fastest allowed frames per move tick (1..BASE_PERIOD)
//   APPLES_PER_LEVEL  apples per speed-level step (used only with SPEEDUP_EN)
//
// Ports
//   clock_25     in   pixel clock; all logic runs on its rising edge
//   reset        in   synchronous, active-high; clears all state
//   start_btn    in   start/restart button, active-high level, debounced
//   pause_btn    in   pause toggle button, active-high level, debounced
//   vga_vs       in   VGA vertical sync (active low) from the sync generator
//   collision    in   1-cycle pulse: the snake hit a wall or itself
//   apple_eaten  in   1-cycle pulse: the snake head is on the apple
//   game_enable  out  1 = render the game layer, 0 = background/title only
//   game_state   out  FSM state: 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   move_tick    out  1-cycle pulse: advance the snake by one cell
//   init_snake   out  1-cycle pulse: reinitialise snake/apple positions
//   grow         out  1-cycle pulse: lengthen the snake
//   score        out  apples eaten in this game, saturating at 255
//   speed_level  out  current speed level
//
// Handshake note: there is no valid/ready traffic here. Every input event is
// either a level (buttons, vga_vs) that is edge-detected internally, or a
// single-cycle pulse that is acted on in the cycle it is seen. Every output
// pulse is registered and lasts exactly one clock.
// -----------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int BASE_PERIOD      = 8,
    parameter int MIN_PERIOD       = 2,
    parameter int APPLES_PER_LEVEL = 4
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       vga_vs,
    input  logic       collision,
    input  logic       apple_eaten,
    output logic       game_enable,
    output logic [1:0] game_state,
    output logic       move_tick,
    output logic       init_snake,
    output logic       grow,
    output logic [7:0] score,
    output logic [3:0] speed_level
);

    // -------------------------------------------------------------------------
    // Parameter sanity checks (elaboration time only).
    // -------------------------------------------------------------------------
    if (BASE_PERIOD < 2) begin : g_bad_base
        $error("snake_game_ctrl: BASE_PERIOD must be >= 2");
    end
    if (MIN_PERIOD < 1 || MIN_PERIOD > BASE_PERIOD) begin : g_bad_min
        $error("snake_game_ctrl: MIN_PERIOD must be in 1..BASE_PERIOD");
    end
    if (APPLES_PER_LEVEL < 1) begin : g_bad_apl
        $error("snake_game_ctrl: APPLES_PER_LEVEL must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Wide enough to hold BASE_PERIOD-1, the largest count ever reached.
    localparam int CNT_W = $clog2(BASE_PERIOD + 1);

    localparam logic [CNT_W-1:0] BASE_M1 = CNT_W'(BASE_PERIOD - 1);

    // -------------------------------------------------------------------------
    // State and edge-detect registers
    // -------------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             start_q;
    logic             pause_q;
    logic             vs_q;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] period_m1;     // active move period minus one
    logic             move_tick_r;
    logic             init_snake_r;
    logic             grow_r;
    logic [7:0]       score_r;

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    logic start_press;
    logic pause_press;
    logic frame_tick;
    logic start_game;
    logic accept_apple;
    logic count_frame;
    logic wrap;

    // A held button produces a single press: only the 0->1 transition counts.
    assign start_press = start_btn & ~start_q;
    assign pause_press = pause_btn & ~pause_q;

    // vga_vs is active low, so the start of each sync pulse marks one frame.
    assign frame_tick  = vs_q & ~vga_vs;

    // A new game can be launched from the title screen or the game-over screen.
    assign start_game   = start_press && ((state == ST_IDLE) || (state == ST_OVER));

    // A collision in the same cycle as an apple wins: the game ends and the
    // apple is not scored.
    assign accept_apple = (state == ST_PLAY) && apple_eaten && !collision;

    // Frames are only counted while playing; PAUSE keeps the partial count so
    // resuming neither adds nor loses a tick.
    assign count_frame  = (state == ST_PLAY) && frame_tick;
    assign wrap         = count_frame && (frame_cnt == period_m1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                // A simultaneous pause press is ignored.
                if (start_press) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (collision)        state_next = ST_OVER;
                else if (pause_press) state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                // Start, collision and apple events have no effect here.
                if (pause_press) state_next = ST_PLAY;
            end
            ST_OVER: begin
                if (start_press) state_next = ST_PLAY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Main sequential logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            vs_q         <= 1'b0;
            frame_cnt    <= '0;
            move_tick_r  <= 1'b0;
            init_snake_r <= 1'b0;
            grow_r       <= 1'b0;
            score_r      <= 8'd0;
        end else begin
            start_q      <= start_btn;
            pause_q      <= pause_btn;
            vs_q         <= vga_vs;
            state        <= state_next;

            // Output pulses are one-cycle registered copies of their events.
            move_tick_r  <= wrap;
            init_snake_r <= start_game;
            grow_r       <= accept_apple;

            // Counter starts at 0 on game start, so the first move tick comes
            // on the period-th frame after entering PLAY.
            if (start_game) begin
                frame_cnt <= '0;
            end else if (wrap) begin
                frame_cnt <= '0;
            end else if (count_frame) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            // Score is held through OVER so it stays on screen until restart.
            if (start_game) begin
                score_r <= 8'd0;
            end else if (accept_apple && (score_r != 8'hFF)) begin
                score_r <= score_r + 8'd1;
            end
        end
    end

`ifdef SPEEDUP_EN
    // -------------------------------------------------------------------------
    // Speed-up logic: level rises every APPLES_PER_LEVEL accepted apples.
    // -------------------------------------------------------------------------
    localparam int APL_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;

    localparam logic [APL_W-1:0] APL_LAST = APL_W'(APPLES_PER_LEVEL - 1);

    logic [3:0]       level_r;
    logic [APL_W-1:0] apple_cnt;
    logic [CNT_W-1:0] period_m1_r;
    logic [CNT_W-1:0] level_period_m1;

    // Period implied by the current level: BASE_PERIOD - level, floored at
    // MIN_PERIOD.
    always_comb begin
        int p;
        p = BASE_PERIOD - int'(level_r);
        if (p < MIN_PERIOD) p = MIN_PERIOD;
        level_period_m1 = CNT_W'(p - 1);
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            level_r     <= 4'd0;
            apple_cnt   <= '0;
            period_m1_r <= BASE_M1;
        end else if (start_game) begin
            level_r     <= 4'd0;
            apple_cnt   <= '0;
            period_m1_r <= BASE_M1;
        end else begin
            // The active period is only reloaded at a counter wrap, so a level
            // change never shortens or stretches the interval in progress.
            if (wrap) begin
                period_m1_r <= level_period_m1;
            end

            if (accept_apple) begin
                if (apple_cnt == APL_LAST) begin
                    apple_cnt <= '0;
                    if (level_r != 4'hF) level_r <= level_r + 4'd1;
                end else begin
                    apple_cnt <= apple_cnt + APL_W'(1);
                end
            end
        end
    end

    assign period_m1   = period_m1_r;
    assign speed_level = level_r;
`else
    // Fixed-speed build: constant period, no level state.
    assign period_m1   = BASE_M1;
    assign speed_level = 4'd0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign game_enable = (state != ST_IDLE);
    assign game_state  = state;
    assign move_tick   = move_tick_r;
    assign init_snake  = init_snake_r;
    assign grow        = grow_r;
    assign score       = score_r;

endmodule
